// File: rtl/ls74163_pkg.sv
// ls74163_pkg: shared state encoding and default widths for the LS74163 timer controller
package ls74163_pkg;
    localparam int STAGES_DEF = 2;
    localparam int W_DEF = 4 * STAGES_DEF;
    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;
endpackage

// File: rtl/ls74163_ctrl_decode.sv
// ls74163_ctrl_decode: combinational decode of state/RCO/pause/abort/mode into counter-chain controls (CLR_L, LD_L, ENT, ENP) plus terminal-edge flag
import ls74163_pkg::*;
module ls74163_ctrl_decode (
    input  state_t state,
    input  logic   RCO,
    input  logic   pause,
    input  logic   abort,
    input  logic   periodic,
    output logic   CLR_L,
    output logic   LD_L,
    output logic   ENT,
    output logic   ENP,
    output logic   term
);
    logic abort_eff;
    logic run;
    always_comb begin
        abort_eff = abort && state != S_INIT;
        run = state == S_RUN;
        term = run && RCO && !pause && !abort_eff;
        CLR_L = !(state == S_INIT || abort_eff || (term && !periodic));
        LD_L = abort_eff ? 1'b1 : !(state == S_LOAD || (term && periodic));
        ENT = run && !abort_eff;
        ENP = run && !pause && !abort_eff;
    end
endmodule

// File: rtl/ls74163_timer_ctrl.sv
// ls74163_timer_ctrl: FSM, shadow registers and tick/done/err pulses sequencing a cascaded LS74163 chain as a programmable interval timer
import ls74163_pkg::*;
module ls74163_timer_ctrl #(
    parameter int STAGES = STAGES_DEF,
    localparam int W = 4 * STAGES
) (
    input  logic         clk,
    input  logic         RST_L,
    input  logic         start,
    input  logic         periodic,
    input  logic [W-1:0] period,
    input  logic         pause,
    input  logic         abort,
    input  logic [W-1:0] Q,
    input  logic         RCO,
    output logic         CLR_L,
    output logic         LD_L,
    output logic         ENT,
    output logic         ENP,
    output logic [W-1:0] D,
    output logic         busy,
    output logic         tick,
    output logic         done,
    output logic         err
);
    state_t       state;
    logic [W-1:0] shadow_period;
    logic         shadow_periodic;
    logic         term;
    logic         q_unused;
    ls74163_ctrl_decode u_decode (
        .state    (state),
        .RCO      (RCO),
        .pause    (pause),
        .abort    (abort),
        .periodic (shadow_periodic),
        .CLR_L    (CLR_L),
        .LD_L     (LD_L),
        .ENT      (ENT),
        .ENP      (ENP),
        .term     (term)
    );
    // Preload is the two's complement of the period so the chain reaches all-ones (RCO) after period-1 enables.
    assign D = -shadow_period;
    assign busy = state == S_LOAD || state == S_RUN;
    assign q_unused = ^Q;
    always_ff @(posedge clk or negedge RST_L) begin
        if (!RST_L) begin
            state <= S_INIT;
            shadow_period <= '0;
            shadow_periodic <= 1'b0;
            tick <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            if (abort && state != S_INIT)
                state <= S_IDLE;
            else
                case (state)
                    S_INIT: state <= S_IDLE;
                    S_IDLE:
                        if (start && period != '0) begin
                            shadow_period <= period;
                            shadow_periodic <= periodic;
                            state <= S_LOAD;
                        end else if (start)
                            err <= 1'b1;
                    S_LOAD: state <= S_RUN;
                    S_RUN:
                        if (term) begin
                            tick <= 1'b1;
                            if (!shadow_periodic) begin
                                done <= 1'b1;
                                state <= S_DONE;
                            end
                        end
                    default: state <= S_IDLE;
                endcase
        end
    end
endmodule

// File: tb/tb_ls74163_timer_ctrl.sv
// tb_ls74163_timer_ctrl: directed self-checking bench driving the controller against a two-stage LS74163 chain model
module tb_ls74163_timer_ctrl;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         RST_L, start, periodic, pause, abort;
    logic [W-1:0] period, Q, D;
    logic         RCO, CLR_L, LD_L, ENT, ENP, busy, tick, done, err;
    logic         rco0;
    int           n_checks = 0;
    int           n_fail = 0;

    ls74163_timer_ctrl #(.STAGES(2)) dut (
        .clk(clk), .RST_L(RST_L), .start(start), .periodic(periodic), .period(period),
        .pause(pause), .abort(abort), .Q(Q), .RCO(RCO), .CLR_L(CLR_L), .LD_L(LD_L),
        .ENT(ENT), .ENP(ENP), .D(D), .busy(busy), .tick(tick), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Two LS74163 stages: sync clear over sync load over count; stage 1 ENT from stage 0 RCO.
    assign rco0 = ENT && Q[3:0] == 4'hF;
    assign RCO = rco0 && Q[7:4] == 4'hF;
    always_ff @(posedge clk) begin
        Q[3:0] <= !CLR_L ? 4'h0 : !LD_L ? D[3:0] : (ENT && ENP) ? Q[3:0] + 4'h1 : Q[3:0];
        Q[7:4] <= !CLR_L ? 4'h0 : !LD_L ? D[7:4] : (rco0 && ENP) ? Q[7:4] + 4'h1 : Q[7:4];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        RST_L = 1'b0; start = 1'b0; periodic = 1'b0; pause = 1'b0; abort = 1'b0; period = '0;
        #2;
        chk("rst_clr", CLR_L, 0); chk("rst_ld", LD_L, 1); chk("rst_ent", ENT, 0);
        chk("rst_enp", ENP, 0); chk("rst_busy", busy, 0);
        chk("rst_pulses", {tick, done, err}, 0);
        @(negedge clk); RST_L = 1'b1;
        cyc();
        chk("init_q", Q, 8'h00); chk("idle_clr", CLR_L, 1); chk("idle_ld", LD_L, 1);
        chk("idle_busy", busy, 0);

        // One-shot, period 5
        start = 1'b1; periodic = 1'b0; period = 8'd5;
        cyc(); start = 1'b0; #1;
        chk("os_load_ld", LD_L, 0); chk("os_load_busy", busy, 1); chk("os_d", D, 8'hFB);
        chk("os_load_ent", ENT, 0);
        cyc(); chk("os_q0", Q, 8'hFB); chk("os_ent", ENT, 1); chk("os_enp", ENP, 1);
        cyc(); chk("os_q1", Q, 8'hFC);
        cyc(); chk("os_q2", Q, 8'hFD);
        cyc(); chk("os_q3", Q, 8'hFE);
        cyc(); chk("os_q4", Q, 8'hFF); chk("os_term_clr", CLR_L, 0); chk("os_tick_early", tick, 0);
        cyc(); chk("os_q5", Q, 8'h00); chk("os_tick", tick, 1); chk("os_done", done, 1);
        chk("os_busy", busy, 0);
        cyc(); chk("os_after", {tick, done, busy}, 0);

        // Periodic, period 3
        start = 1'b1; periodic = 1'b1; period = 8'd3;
        cyc(); start = 1'b0;
        cyc(); chk("per_first", Q, 8'hFD); chk("per_first_tick", tick, 0);
        for (int k = 0; k < 4; k++) begin
            chk("per_fd", Q, 8'hFD);
            cyc(); chk("per_fe", Q, 8'hFE); chk("per_fe_tick", tick, 0);
            cyc(); chk("per_ff", Q, 8'hFF); chk("per_ff_ld", LD_L, 0); chk("per_ff_tick", tick, 0);
            cyc(); chk("per_tick", tick, 1); chk("per_done", done, 0); chk("per_busy", busy, 1);
        end
        abort = 1'b1; #1;
        chk("per_abort_clr", CLR_L, 0);
        cyc(); abort = 1'b0; #1;
        chk("per_abort_q", Q, 8'h00); chk("per_abort_busy", busy, 0); chk("per_abort_tick", tick, 0);

        // Pause, periodic period 4
        start = 1'b1; periodic = 1'b1; period = 8'd4;
        cyc(); start = 1'b0;
        cyc(); chk("pa_q0", Q, 8'hFC);
        cyc(); chk("pa_q1", Q, 8'hFD);
        cyc(); chk("pa_q2", Q, 8'hFE);
        pause = 1'b1; #1; chk("pa_enp", ENP, 0);
        cyc(); chk("pa_hold1", Q, 8'hFE);
        cyc(); chk("pa_hold2", Q, 8'hFE); chk("pa_tick_hold", tick, 0);
        pause = 1'b0; #1; chk("pa_enp_back", ENP, 1);
        cyc(); chk("pa_ff", Q, 8'hFF); chk("pa_ff_tick", tick, 0);
        cyc(); chk("pa_reload", Q, 8'hFC); chk("pa_tick", tick, 1);
        cyc(); chk("pb_q1", Q, 8'hFD);
        cyc(); chk("pb_q2", Q, 8'hFE);
        cyc(); chk("pb_q3", Q, 8'hFF);
        pause = 1'b1; #1; chk("pb_ld", LD_L, 1); chk("pb_enp", ENP, 0); chk("pb_clr", CLR_L, 1);
        cyc(); chk("pb_hold", Q, 8'hFF); chk("pb_no_tick", tick, 0);
        pause = 1'b0; #1; chk("pb_ld_back", LD_L, 0);
        cyc(); chk("pb_reload", Q, 8'hFC); chk("pb_tick", tick, 1);
        abort = 1'b1;
        cyc(); abort = 1'b0; #1; chk("pb_abort_q", Q, 8'h00);

        // Illegal start with period 0
        start = 1'b1; period = 8'd0;
        cyc(); start = 1'b0; #1;
        chk("err_pulse", err, 1); chk("err_busy", busy, 0); chk("err_q", Q, 8'h00);
        chk("err_ld", LD_L, 1);
        cyc(); chk("err_clear", err, 0);

        // Period 1 periodic
        start = 1'b1; periodic = 1'b1; period = 8'd1;
        cyc(); start = 1'b0; #1; chk("p1_d", D, 8'hFF);
        cyc(); chk("p1_q0", Q, 8'hFF); chk("p1_ld0", LD_L, 0); chk("p1_tick0", tick, 0);
        period = 8'd7; periodic = 1'b0;
        cyc(); chk("p1_q1", Q, 8'hFF); chk("p1_tick1", tick, 1); chk("p1_ld1", LD_L, 0);
        cyc(); chk("p1_tick2", tick, 1); chk("p1_d_kept", D, 8'hFF); chk("p1_busy", busy, 1);
        abort = 1'b1;
        cyc(); abort = 1'b0; #1;

        // Abort with simultaneous start at Q=FC
        start = 1'b1; periodic = 1'b0; period = 8'd5;
        cyc(); start = 1'b0;
        cyc(); chk("ab_q0", Q, 8'hFB);
        cyc(); chk("ab_q1", Q, 8'hFC);
        abort = 1'b1; start = 1'b1; #1;
        chk("ab_clr", CLR_L, 0); chk("ab_ld", LD_L, 1); chk("ab_enp", ENP, 0);
        cyc(); abort = 1'b0; start = 1'b0; #1;
        chk("ab_q", Q, 8'h00); chk("ab_busy", busy, 0); chk("ab_pulses", {tick, done, err}, 0);
        cyc(); chk("ab_stay_idle", busy, 0); chk("ab_stay_q", Q, 8'h00);

        // Reset mid-run
        start = 1'b1; period = 8'd5;
        cyc(); start = 1'b0;
        cyc(); chk("rr_q0", Q, 8'hFB);
        cyc(); chk("rr_q1", Q, 8'hFC);
        RST_L = 1'b0; #1;
        chk("rr_clr", CLR_L, 0); chk("rr_busy", busy, 0); chk("rr_ent", ENT, 0);
        cyc(); RST_L = 1'b1;
        cyc(); chk("rr_q", Q, 8'h00); chk("rr_idle_clr", CLR_L, 1); chk("rr_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
